cache_cmd_sequencer: RTL and testbench
======================================

# cache_cmd_sequencer

Command sequencer that sits directly upstream of the L1 cache model. Accepts trace commands (operation code `n` plus 32-bit address) from the trace reader, buffers them in a small FIFO, and presents them to the cache one at a time: a one-cycle `valid` pulse, then a wait for the cache's operation-complete strobe before the next issue. Illegal operation codes are filtered before they reach the cache.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2
- TIMEOUT, 64, cycles allowed in WAIT before abort (used only with CMD_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; everything on posedge
- rstb  in  1  asynchronous, active-low reset
- in_valid  in  1  trace command present
- in_n  in  4  operation code
- in_address  in  32  command address
- in_ready  out  1  FIFO can accept; equals !full
- done  in  1  cache operation finished (cache `opr_finished`)
- valid  out  1  one-cycle issue pulse to cache
- n  out  4  operation code to cache; held until next issue
- address  out  32  address to cache; held until next issue
- busy  out  1  high in ISSUE/WAIT/CLEAR or FIFO non-empty
- issued_cntr  out  16  commands issued to cache
- drop_cntr  out  16  illegal codes discarded
- timeout_err  out  1  sticky; exists only with CMD_TIMEOUT_EN

## Operation
- Legal codes: 0,1,2,3,4,5,6,8,9. Codes 7 and 10–15 accepted on the handshake (in_valid & in_ready) but not written; drop_cntr +1.
- Legal code with in_valid & in_ready → written to FIFO tail.
- FSM states: IDLE, ISSUE, WAIT, CLEAR.
  - IDLE: FIFO non-empty → pop head into n/address registers; go to CLEAR if head code is 8, else ISSUE.
  - ISSUE: valid=1 for exactly this cycle; issued_cntr +1; → WAIT.
  - WAIT: done=1 → if FIFO non-empty, pop and go to ISSUE/CLEAR directly (no IDLE bubble); else → IDLE.
  - CLEAR: valid=1 for one cycle with n=8; issued_cntr +1; no done expected (cache self-resets); → IDLE.
- done outside WAIT is ignored.
- Counters saturate at 16'hFFFF.
- Reset: FSM=IDLE, FIFO empty, valid=0, n=0, address=0, busy=0, in_ready=1, both counters 0, timeout_err=0. Reset mid-WAIT discards the in-flight command and all queued entries.

## Timing
- FIFO write at edge t → entry at head from t+1 → IDLE pops at t+1 edge → valid high during cycle t+2 (2-cycle minimum latency from accept to issue).
- done high in cycle k with FIFO non-empty → next valid in cycle k+1; empty → IDLE at k+1.
- n/address change only on the pop edge; stable for the whole valid cycle and the following WAIT.
- Full FIFO: in_ready=0 even if a pop occurs the same cycle (no pass-through write).
- Push and pop in the same cycle on a non-full FIFO: both take effect; occupancy unchanged.
- Pointers wrap modulo DEPTH; full/empty from a DEPTH+1-range occupancy count.

## Configuration
- CMD_TIMEOUT_EN defined: 16-bit cycle counter runs in WAIT and clears on entry. Reaching TIMEOUT without done → timeout_err set (sticky until rstb), command abandoned, FSM → IDLE, queued entries retained.
- Undefined: no counter, no timeout_err port, WAIT waits indefinitely.

## Structure
- Package cache_cmd_pkg: operation-code constants (READ_REQ_L1_D=0 … CLR_CACHE_RST=8, PRINT_CONTENTS=9, matching the cache's decode), FSM state enum, FIFO entry struct {n[3:0], address[31:0]}, legal-code function.
- One sub-module: cache_cmd_fifo (parameterised DEPTH, entry struct, push/pop/full/empty/head). FSM, filter and counters stay in the top level.

## Test plan
- Reset, then push {n=0, addr=32'h1000_0040} at cycle 0 → valid pulse in cycle 2 with n=0, address=32'h1000_0040; issued_cntr=1.
- Push 3 commands back-to-back; assert done 4 cycles after each valid → each subsequent valid exactly 1 cycle after done; issued_cntr=3, busy falls after last done.
- Push n=7 and n=12 → no valid; drop_cntr=2; FIFO stays empty.
- Push n=8 → valid for one cycle with n=8; no done required; next queued command issues from IDLE.
- Fill DEPTH=8 with done held low → in_ready=0 after 8 accepts (or 9, with one popped into WAIT); pulse done → in_ready returns to 1 the next cycle.
- CMD_TIMEOUT_EN, TIMEOUT=64, never assert done → timeout_err=1 64 cycles into WAIT; next queued entry issues; assert rstb low mid-WAIT → all outputs at reset values.

Source files
------------

// File: rtl/cache_cmd_pkg.sv
// Shared types and constants for the cache command sequencer.
// Operation codes mirror the L1 cache model's command decode.
package cache_cmd_pkg;

   localparam logic [3:0] READ_REQ_L1_D    = 4'd0;
   localparam logic [3:0] WRITE_REQ_L1_D   = 4'd1;
   localparam logic [3:0] READ_REQ_L1_I    = 4'd2;
   localparam logic [3:0] SNOOP_INVALIDATE = 4'd3;
   localparam logic [3:0] SNOOP_READ       = 4'd4;
   localparam logic [3:0] SNOOP_WRITE      = 4'd5;
   localparam logic [3:0] SNOOP_RWIM       = 4'd6;
   localparam logic [3:0] CLR_CACHE_RST    = 4'd8;
   localparam logic [3:0] PRINT_CONTENTS   = 4'd9;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StClear} seq_state_e;

   typedef struct packed {
      logic [3:0]  n;
      logic [31:0] address;
   } cmd_entry_t;

   function automatic logic is_legal_code(input logic [3:0] code);
      return (code <= SNOOP_RWIM) || (code == CLR_CACHE_RST) || (code == PRINT_CONTENTS);
   endfunction

endpackage

// File: rtl/cache_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), occupancy count drives full/empty.
module cache_cmd_fifo
   import cache_cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk_i,
   input  logic       rstb_i,
   input  logic       push_i,
   input  logic       pop_i,
   input  cmd_entry_t wdata_i,
   output logic       full_o,
   output logic       empty_o,
   output cmd_entry_t head_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   cmd_entry_t      mem_q [DEPTH];
   logic            do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; only occupancy defines validity.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/cache_cmd_sequencer.sv
// Filters trace commands, queues them and issues one at a time to the L1 cache.
// Optional WAIT watchdog enabled by defining CMD_TIMEOUT_EN.
module cache_cmd_sequencer
   import cache_cmd_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rstb_i,
   input  logic        in_valid_i,
   input  logic [3:0]  in_n_i,
   input  logic [31:0] in_address_i,
   output logic        in_ready_o,
   input  logic        done_i,
   output logic        valid_o,
   output logic [3:0]  n_o,
   output logic [31:0] address_o,
   output logic        busy_o,
   output logic [15:0] issued_cntr_o,
`ifdef CMD_TIMEOUT_EN
   output logic        timeout_err_o,
`endif
   output logic [15:0] drop_cntr_o
);

   seq_state_e  state_q, state_d;
   logic [3:0]  n_q;
   logic [31:0] addr_q;
   logic [15:0] issued_q, drop_q;
   logic        fifo_full, fifo_empty, pop, push, accept, tmo_hit;
   cmd_entry_t  head, wdata;

   assign accept     = in_valid_i & in_ready_o;
   assign push       = accept & is_legal_code(in_n_i);
   assign wdata      = '{n: in_n_i, address: in_address_i};
   assign in_ready_o = ~fifo_full;

   cache_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstb_i  (rstb_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head)
   );

`ifdef CMD_TIMEOUT_EN
   logic [15:0] tmo_cnt_q;
   logic        tmo_err_q;

   // Counter is zero on WAIT entry since it only runs while in WAIT.
   assign tmo_hit       = (state_q == StWait) & ~done_i & (tmo_cnt_q == 16'(TIMEOUT - 1));
   assign timeout_err_o = tmo_err_q;

   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= (state_q == StWait) ? tmo_cnt_q + 16'd1 : 16'd0;
         if (tmo_hit) tmo_err_q <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = (head.n == CLR_CACHE_RST) ? StClear : StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (done_i) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = (head.n == CLR_CACHE_RST) ? StClear : StIssue;
               end else begin
                  state_d = StIdle;
               end
            end else if (tmo_hit) begin
               state_d = StIdle;
            end
         end
         StClear: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      valid_o       = (state_q == StIssue) || (state_q == StClear);
      busy_o        = (state_q != StIdle) || !fifo_empty;
      n_o           = n_q;
      address_o     = addr_q;
      issued_cntr_o = issued_q;
      drop_cntr_o   = drop_q;
   end

   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         n_q      <= '0;
         addr_q   <= '0;
         issued_q <= '0;
         drop_q   <= '0;
      end else begin
         if (pop) begin
            n_q    <= head.n;
            addr_q <= head.address;
         end
         if (valid_o && issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
         if (accept && !is_legal_code(in_n_i) && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// Directed bench for cache_cmd_sequencer; define CMD_TIMEOUT_EN to cover the watchdog.
module tb_cache_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_n = '0;
   logic [31:0] in_address = '0;
   logic        in_ready;
   logic        done = 1'b0;
   logic        valid;
   logic [3:0]  n;
   logic [31:0] address;
   logic        busy;
   logic [15:0] issued_cntr, drop_cntr;
`ifdef CMD_TIMEOUT_EN
   logic        timeout_err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int accepts;

   always #5 clk = ~clk;

   cache_cmd_sequencer #(
      .DEPTH   (8),
      .TIMEOUT (64)
   ) dut (
      .clk_i         (clk),
      .rstb_i        (rstb),
      .in_valid_i    (in_valid),
      .in_n_i        (in_n),
      .in_address_i  (in_address),
      .in_ready_o    (in_ready),
      .done_i        (done),
      .valid_o       (valid),
      .n_o           (n),
      .address_o     (address),
      .busy_o        (busy),
      .issued_cntr_o (issued_cntr),
`ifdef CMD_TIMEOUT_EN
      .timeout_err_o (timeout_err),
`endif
      .drop_cntr_o   (drop_cntr)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_valid"},   32'(valid), 32'd0);
      check_eq({tag, "_n"},       32'(n), 32'd0);
      check_eq({tag, "_addr"},    address, 32'd0);
      check_eq({tag, "_busy"},    32'(busy), 32'd0);
      check_eq({tag, "_ready"},   32'(in_ready), 32'd1);
      check_eq({tag, "_issued"},  32'(issued_cntr), 32'd0);
      check_eq({tag, "_drop"},    32'(drop_cntr), 32'd0);
`ifdef CMD_TIMEOUT_EN
      check_eq({tag, "_tmo"},     32'(timeout_err), 32'd0);
`endif
   endtask

   // Pulse done during the current cycle; returns one cycle later.
   task automatic pulse_done();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   initial begin
      // Reset
      #3;
      check_reset_vals("rst");
      rstb = 1'b1;
      tick();

      // Single command: accept in cycle 0, issue in cycle 2
      in_valid = 1'b1; in_n = 4'd0; in_address = 32'h1000_0040;
      tick();
      in_valid = 1'b0;
      check_eq("lat_c1_valid", 32'(valid), 32'd0);
      check_eq("lat_c1_busy", 32'(busy), 32'd1);
      tick();
      check_eq("lat_c2_valid", 32'(valid), 32'd1);
      check_eq("lat_c2_n", 32'(n), 32'd0);
      check_eq("lat_c2_addr", address, 32'h1000_0040);
      tick();
      check_eq("lat_wait_valid", 32'(valid), 32'd0);
      check_eq("lat_issued", 32'(issued_cntr), 32'd1);
      pulse_done();
      check_eq("lat_idle_busy", 32'(busy), 32'd0);

      // Three back-to-back, done four cycles after each valid
      in_valid = 1'b1; in_n = 4'd1; in_address = 32'hA000_0001;
      tick();
      in_n = 4'd2; in_address = 32'hA000_0002;
      tick();
      check_eq("b2b0_valid", 32'(valid), 32'd1);
      check_eq("b2b0_addr", address, 32'hA000_0001);
      in_n = 4'd3; in_address = 32'hA000_0003;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      pulse_done();
      check_eq("b2b1_valid", 32'(valid), 32'd1);
      check_eq("b2b1_n", 32'(n), 32'd2);
      check_eq("b2b1_addr", address, 32'hA000_0002);
      repeat (4) tick();
      pulse_done();
      check_eq("b2b2_valid", 32'(valid), 32'd1);
      check_eq("b2b2_n", 32'(n), 32'd3);
      repeat (4) tick();
      pulse_done();
      check_eq("b2b_end_valid", 32'(valid), 32'd0);
      check_eq("b2b_end_busy", 32'(busy), 32'd0);
      check_eq("b2b_issued", 32'(issued_cntr), 32'd4);

      // Illegal codes are dropped
      in_valid = 1'b1; in_n = 4'd7; in_address = 32'hDEAD_0007;
      tick();
      in_n = 4'd12; in_address = 32'hDEAD_000C;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("drop_valid", 32'(valid), 32'd0);
         check_eq("drop_busy", 32'(busy), 32'd0);
         tick();
      end
      check_eq("drop_cntr", 32'(drop_cntr), 32'd2);
      check_eq("drop_issued", 32'(issued_cntr), 32'd4);

      // Clear command needs no done, then next entry issues from IDLE
      in_valid = 1'b1; in_n = 4'd8; in_address = 32'hC1C1_0008;
      tick();
      in_n = 4'd4; in_address = 32'hB000_0004;
      tick();
      in_valid = 1'b0;
      check_eq("clr_valid", 32'(valid), 32'd1);
      check_eq("clr_n", 32'(n), 32'd8);
      check_eq("clr_addr", address, 32'hC1C1_0008);
      tick();
      check_eq("clr_gap_valid", 32'(valid), 32'd0);
      check_eq("clr_gap_busy", 32'(busy), 32'd1);
      tick();
      check_eq("clr_next_valid", 32'(valid), 32'd1);
      check_eq("clr_next_n", 32'(n), 32'd4);
      check_eq("clr_next_addr", address, 32'hB000_0004);
      tick();
      pulse_done();
      check_eq("clr_issued", 32'(issued_cntr), 32'd6);

      // Fill the FIFO with done held low: one entry in WAIT plus eight queued
      accepts  = 0;
      in_valid = 1'b1;
      in_n     = 4'd5;
      for (int i = 0; i < 12; i++) begin
         in_address = 32'h2000_0000 + 32'(accepts);
         if (in_ready) accepts++;
         tick();
      end
      in_valid = 1'b0;
      check_eq("fill_accepts", 32'(accepts), 32'd9);
      check_eq("fill_ready", 32'(in_ready), 32'd0);
      check_eq("fill_addr", address, 32'h2000_0000);
      check_eq("fill_issued", 32'(issued_cntr), 32'd7);
      pulse_done();
      check_eq("fill_ready_back", 32'(in_ready), 32'd1);
      check_eq("fill_valid1", 32'(valid), 32'd1);
      check_eq("fill_addr1", address, 32'h2000_0001);
      for (int j = 2; j < 9; j++) begin
         tick();
         pulse_done();
         check_eq("drain_valid", 32'(valid), 32'd1);
         check_eq("drain_addr", address, 32'h2000_0000 + 32'(j));
      end
      tick();
      pulse_done();
      check_eq("drain_busy", 32'(busy), 32'd0);
      check_eq("drain_issued", 32'(issued_cntr), 32'd15);

`ifdef CMD_TIMEOUT_EN
      // Watchdog: abandon after 64 WAIT cycles, keep the queued entry
      in_valid = 1'b1; in_n = 4'd1; in_address = 32'hE000_0001;
      tick();
      in_n = 4'd2; in_address = 32'hE000_0002;
      tick();
      in_valid = 1'b0;
      check_eq("tmo_first_valid", 32'(valid), 32'd1);
      repeat (64) tick();
      check_eq("tmo_before", 32'(timeout_err), 32'd0);
      tick();
      check_eq("tmo_set", 32'(timeout_err), 32'd1);
      tick();
      check_eq("tmo_next_valid", 32'(valid), 32'd1);
      check_eq("tmo_next_n", 32'(n), 32'd2);
      tick();
      check_eq("tmo_sticky", 32'(timeout_err), 32'd1);
`endif

      // Reset while waiting with entries queued
      in_valid = 1'b1; in_n = 4'd6; in_address = 32'hF000_0006;
      tick();
      in_n = 4'd9; in_address = 32'hF000_0009;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rstb = 1'b0;
      #2;
      check_reset_vals("midrst");
      rstb = 1'b1;
      tick();
      tick();
      check_eq("post_rst_valid", 32'(valid), 32'd0);
      check_eq("post_rst_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
